// File: rtl/adc_multich_stream_packer.sv
// adc_multich_stream_packer
// Buffers NUM_CH parallel ADC sample lanes into one AXI-Stream master per channel.
// Each channel has its own FWFT FIFO, output formatting with an optional overrange tag,
// tlast framing, a saturating drop counter and a sticky overrange flag.
module adc_multich_stream_packer #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned DATA_WIDTH = 14,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned FRAME_LEN  = 256
) (
    input  logic                     m_axis_aclk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     fmt_or_tag,
    input  logic                     cnt_clr,
    input  logic                     s_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_CH-1:0]        s_or,
    output logic                     adc_ready,
    output logic [NUM_CH-1:0]        m_axis_tvalid,
    input  logic [NUM_CH-1:0]        m_axis_tready,
    output logic [NUM_CH*16-1:0]     m_axis_tdata,
    output logic [NUM_CH-1:0]        m_axis_tlast,
    output logic [NUM_CH*16-1:0]     drop_cnt,
    output logic [NUM_CH-1:0]        or_sticky
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned EW = DATA_WIDTH + 1;
    localparam int unsigned FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [FW-1:0] LAST_BEAT = FW'(FRAME_LEN - 1);

    // FIFO entry layout: {overrange, sample}
    logic [EW-1:0] mem_q [NUM_CH][FIFO_DEPTH];

    logic [NUM_CH-1:0][PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [NUM_CH-1:0][PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [NUM_CH-1:0][CW-1:0] count_q, count_d;
    logic [NUM_CH-1:0][FW-1:0] frame_q, frame_d;
    logic [NUM_CH-1:0][15:0]   drop_q, drop_d;
    logic [NUM_CH-1:0][15:0]   tdata_q, tdata_d;
    logic [NUM_CH-1:0]         tvalid_q, tvalid_d;
    logic [NUM_CH-1:0]         tlast_q, tlast_d;
    logic [NUM_CH-1:0]         or_q, or_d;
    logic                      ready_q, ready_d;

    logic [NUM_CH-1:0]         full;
    logic [NUM_CH-1:0]         push;
    logic [NUM_CH-1:0]         drop;
    logic [NUM_CH-1:0]         pop;
    logic [NUM_CH-1:0][EW-1:0] wdata;
    logic [NUM_CH-1:0][EW-1:0] head;

    // Map a FIFO entry to the 16-bit output word in the selected format.
    function automatic logic [15:0] fmt_word(input logic [EW-1:0] e, input logic tag);
        logic [15:0] w;
        if (tag) begin
            w     = '0;
            w[15] = e[EW-1];
        end else begin
            w = {16{e[DATA_WIDTH-1]}};
        end
        w[DATA_WIDTH-1:0] = e[DATA_WIDTH-1:0];
        return w;
    endfunction

    // Per-channel next-state: push/drop/pop decisions, pointers, framing, counters, output word.
    always_comb begin
        full     = '0;
        push     = '0;
        drop     = '0;
        pop      = '0;
        wdata    = '0;
        head     = '0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        frame_d  = frame_q;
        drop_d   = drop_q;
        tdata_d  = '0;
        tvalid_d = '0;
        tlast_d  = '0;
        or_d     = or_q;
        ready_d  = 1'b1;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            // Fullness is taken before any same-cycle pop, so a push into a full FIFO drops.
            full[c]  = (count_q[c] == FULL_CNT);
            push[c]  = s_valid && enable && !full[c];
            drop[c]  = s_valid && enable && full[c];
            pop[c]   = tvalid_q[c] && m_axis_tready[c];
            wdata[c] = {s_or[c], s_data[c*DATA_WIDTH +: DATA_WIDTH]};

            wr_ptr_d[c] = push[c] ? wr_ptr_q[c] + 1'b1 : wr_ptr_q[c];
            rd_ptr_d[c] = pop[c]  ? rd_ptr_q[c] + 1'b1 : rd_ptr_q[c];
            count_d[c]  = count_q[c] + CW'(push[c]) - CW'(pop[c]);

            // New head lands in the same cycle it is written when the FIFO drains to empty.
            head[c] = (push[c] && (wr_ptr_q[c] == rd_ptr_d[c])) ? wdata[c]
                                                                 : mem_q[c][rd_ptr_d[c]];

            if (pop[c]) begin
                frame_d[c] = (frame_q[c] == LAST_BEAT) ? '0 : frame_q[c] + 1'b1;
            end

            tvalid_d[c] = (count_d[c] != '0);
            tdata_d[c]  = tvalid_d[c] ? fmt_word(head[c], fmt_or_tag) : '0;
            tlast_d[c]  = tvalid_d[c] && (frame_d[c] == LAST_BEAT);

            if (cnt_clr) begin
                drop_d[c] = drop[c] ? 16'd1 : 16'd0;
            end else if (drop[c] && (drop_q[c] != 16'hFFFF)) begin
                drop_d[c] = drop_q[c] + 16'd1;
            end

            or_d[c] = (s_valid && enable && s_or[c]) || (or_q[c] && !cnt_clr);

            if (count_d[c] == FULL_CNT) begin
                ready_d = 1'b0;
            end
        end
    end

    // Control and status registers with synchronous reset.
    always_ff @(posedge m_axis_aclk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            frame_q  <= '0;
            drop_q   <= '0;
            tdata_q  <= '0;
            tvalid_q <= '0;
            tlast_q  <= '0;
            or_q     <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            frame_q  <= frame_d;
            drop_q   <= drop_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            or_q     <= or_d;
            ready_q  <= ready_d;
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge m_axis_aclk) begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (push[c]) begin
                mem_q[c][wr_ptr_q[c]] <= wdata[c];
            end
        end
    end

    assign adc_ready     = ready_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;
    assign drop_cnt      = drop_q;
    assign or_sticky     = or_q;

endmodule
